core_seq: RTL and testbench

Instruction sequencer for the single attention core. It generates the 20-bit `inst` word cycle by cycle for one complete Q·K pass: Q/K load into the SRAMs, kernel load into the MAC array, execute, and the ofifo-to-pmem drain. In QK mode it also runs the SFP normalization window. It replaces hand-written testbench instruction streams and sits directly in front of `core.inst`.

---
 rtl/core_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_core_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// core_seq -- instruction sequencer for the single attention core.
//
// Runs one complete Q*K pass by emitting the 20-bit core instruction word one
// cycle at a time:
//   Q load -> K load -> kernel load -> bubble -> execute -> drain -> SFP
// The SFP step is skipped in VN mode.
//
// Ports
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous, active-high; returns to IDLE, outputs 0
//   start       in   1   launch pulse, honoured only in IDLE with n_q in 1..qmax
//   n_q         in   5   number of Q vectors for the pass (latched on start)
//   vn_mode     in   1   VN mode (latched on start); drives inst[19], skips SFP
//   in_valid    in   1   host mem_in word is valid this cycle
//   in_ready    out  1   sequencer accepts mem_in this cycle (WR_Q / WR_K)
//   fifo_valid  in   1   core ofifo o_valid, counted during DRAIN
//   inst        out  20  registered core instruction word
//   busy        out  1   high in every state except IDLE
//   done        out  1   one-cycle pulse on the final cycle of a pass
//   state_dbg   out  4   current FSM state encoding, for observation only
//
// Handshake: in_ready depends on the state alone. A host word is transferred
// on every rising edge where in_valid && in_ready are both high. The matching
// write bits show up on inst in the cycle that follows that edge.
//
// Timing model: inst is a register. The bits a state computes in one cycle
// appear on inst in the next cycle. So the inst stream trails the state
// sequence by exactly one cycle. The FIN state is the cycle in which the last
// bits of the pass are visible on inst, and done is high in that state.
module core_seq #(
    parameter int col     = 8,
    parameter int qmax    = 16,
    parameter int sfp_len = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  n_q,
    input  logic        vn_mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        fifo_valid,
    output logic [19:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        WR_Q  = 4'd1,
        WR_K  = 4'd2,
        LD_K  = 4'd3,
        GAP   = 4'd4,
        EXEC  = 4'd5,
        DRAIN = 4'd6,
        SFP   = 4'd7,
        FIN   = 4'd8
    } state_t;

    // Instruction bit positions
    localparam int B_VN   = 19;
    localparam int B_SFP  = 16;
    localparam int B_EXE  = 7;
    localparam int B_KLD  = 6;
    localparam int B_QRD  = 5;
    localparam int B_QWR  = 4;
    localparam int B_KRD  = 3;
    localparam int B_KWR  = 2;

    localparam logic [4:0] COL_L    = 5'(col);
    localparam logic [4:0] COL_M1   = 5'(col - 1);
    localparam logic [4:0] QMAX_L   = 5'(qmax);
    localparam logic [4:0] SFP_M1   = 5'(sfp_len - 1);

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [4:0]  nq_r, nq_nx;
    logic        vn_r, vn_nx;
    logic [19:0] inst_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            nq_r  <= '0;
            vn_r  <= 1'b0;
            inst  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            nq_r  <= nq_nx;
            vn_r  <= vn_nx;
            inst  <= inst_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        nq_nx          = nq_r;
        vn_nx          = vn_r;
        inst_nx        = '0;
        inst_nx[B_VN]  = vn_r;

        case (state)
            IDLE: begin
                inst_nx = '0;
                if (start && (n_q != 5'd0) && (n_q <= QMAX_L)) begin
                    nq_nx         = n_q;
                    vn_nx         = vn_mode;
                    cnt_nx        = '0;
                    state_nx      = WR_Q;
                    // The first WR_Q cycle already carries the new mode bit.
                    inst_nx[B_VN] = vn_mode;
                end
            end

            WR_Q: begin
                if (in_valid) begin
                    inst_nx[B_QWR]   = 1'b1;
                    inst_nx[15:12]   = cnt[3:0];
                    if (cnt == nq_r - 5'd1) begin
                        cnt_nx   = '0;
                        state_nx = WR_K;
                    end else begin
                        cnt_nx = cnt + 5'd1;
                    end
                end
            end

            WR_K: begin
                if (in_valid) begin
                    inst_nx[B_KWR]   = 1'b1;
                    inst_nx[15:12]   = cnt[3:0];
                    if (cnt == COL_M1) begin
                        cnt_nx   = '0;
                        state_nx = LD_K;
                    end else begin
                        cnt_nx = cnt + 5'd1;
                    end
                end
            end

            // col+1 cycles. The kmem read for row k overlaps the array load of
            // row k-1, which covers the one-cycle SRAM read latency.
            LD_K: begin
                if (cnt < COL_L) begin
                    inst_nx[B_KRD] = 1'b1;
                    inst_nx[15:12] = cnt[3:0];
                end
                if (cnt != 5'd0) begin
                    inst_nx[B_KLD] = 1'b1;
                end
                if (cnt == COL_L) begin
                    cnt_nx   = '0;
                    state_nx = GAP;
                end else begin
                    cnt_nx = cnt + 5'd1;
                end
            end

            GAP: begin
                cnt_nx   = '0;
                state_nx = EXEC;
            end

            // n_q+1 cycles. Execute trails qmem_rd by one cycle for the same
            // SRAM latency reason as LD_K.
            EXEC: begin
                if (cnt < nq_r) begin
                    inst_nx[B_QRD] = 1'b1;
                    inst_nx[15:12] = cnt[3:0];
                end
                if (cnt != 5'd0) begin
                    inst_nx[B_EXE] = 1'b1;
                end
                if (cnt == nq_r) begin
                    cnt_nx   = '0;
                    state_nx = DRAIN;
                end else begin
                    cnt_nx = cnt + 5'd1;
                end
            end

            DRAIN: begin
                if (fifo_valid) begin
                    if (cnt == nq_r - 5'd1) begin
                        cnt_nx   = '0;
                        state_nx = vn_r ? FIN : SFP;
                    end else begin
                        cnt_nx = cnt + 5'd1;
                    end
                end
            end

            SFP: begin
                inst_nx[B_SFP] = 1'b1;
                if (cnt == SFP_M1) begin
                    cnt_nx   = '0;
                    state_nx = FIN;
                end else begin
                    cnt_nx = cnt + 5'd1;
                end
            end

            FIN: begin
                inst_nx  = '0;
                state_nx = IDLE;
            end

            default: begin
                inst_nx  = '0;
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == WR_Q) || (state == WR_K);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign state_dbg = state;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: reset values, ignored starts, a full QK pass
// with the per-cycle inst sequence, WR_Q backpressure, an asynchronous reset
// during EXEC, and a full VN pass with n_q=16.
module tb_core_seq;

    logic        clk = 1'b0;
    logic        reset, start, vn_mode, in_valid, fifo_valid;
    logic        in_ready, busy, done;
    logic [4:0]  n_q;
    logic [19:0] inst;
    logic [3:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [19:0] VN  = 20'h80000;
    localparam logic [19:0] SFP = 20'h10000;
    localparam logic [19:0] EXE = 20'h00080;
    localparam logic [19:0] KLD = 20'h00040;
    localparam logic [19:0] QRD = 20'h00020;
    localparam logic [19:0] QWR = 20'h00010;
    localparam logic [19:0] KRD = 20'h00008;
    localparam logic [19:0] KWR = 20'h00004;

    localparam logic [19:0] S_IDLE  = 20'd0;
    localparam logic [19:0] S_WR_Q  = 20'd1;
    localparam logic [19:0] S_WR_K  = 20'd2;
    localparam logic [19:0] S_LD_K  = 20'd3;
    localparam logic [19:0] S_GAP   = 20'd4;
    localparam logic [19:0] S_DRAIN = 20'd6;
    localparam logic [19:0] S_SFP   = 20'd7;
    localparam logic [19:0] S_FIN   = 20'd8;

    core_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_q        (n_q),
        .vn_mode    (vn_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_valid (fifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] adr(input int a);
        logic [19:0] r;
        r = '0;
        r[15:12] = a[3:0];
        return r;
    endfunction

    task automatic phase_k(input logic [19:0] base);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("wr_k_inst", inst, base | KWR | adr(i));
        end
        chk("ld_k_entry_state", 20'(state_dbg), S_LD_K);
        chk("ld_k_in_ready", 20'(in_ready), 20'd0);
    endtask

    task automatic phase_ldk(input logic [19:0] base);
        logic [19:0] e;
        for (int k = 0; k <= 8; k++) begin
            tick();
            e = base;
            if (k < 8) e = e | KRD | adr(k);
            if (k >= 1) e = e | KLD;
            chk("ld_k_inst", inst, e);
        end
        chk("gap_state", 20'(state_dbg), S_GAP);
    endtask

    task automatic phase_gap(input logic [19:0] base);
        tick();
        chk("gap_inst", inst, base);
    endtask

    task automatic phase_exec(input logic [19:0] base, input int nq, input int ncyc);
        logic [19:0] e;
        for (int k = 0; k < ncyc; k++) begin
            tick();
            e = base;
            if (k < nq) e = e | QRD | adr(k);
            if (k >= 1) e = e | EXE;
            chk("exec_inst", inst, e);
        end
    endtask

    initial begin
        int pat [7];
        int a;
        pat = '{1, 0, 0, 1, 1, 0, 1};

        reset = 1'b1; start = 1'b0; n_q = 5'd0; vn_mode = 1'b0;
        in_valid = 1'b0; fifo_valid = 1'b0;
        tick();
        tick();
        chk("rst_inst", inst, 20'd0);
        chk("rst_busy", 20'(busy), 20'd0);
        chk("rst_done", 20'(done), 20'd0);
        chk("rst_in_ready", 20'(in_ready), 20'd0);
        chk("rst_state", 20'(state_dbg), S_IDLE);
        reset = 1'b0;
        tick();

        // start with n_q=0 is ignored
        start = 1'b1; n_q = 5'd0;
        tick();
        start = 1'b0;
        chk("nq0_busy", 20'(busy), 20'd0);
        chk("nq0_state", 20'(state_dbg), S_IDLE);
        tick();
        chk("nq0_inst", inst, 20'd0);

        // ---------------- full QK pass, n_q=8 ----------------
        start = 1'b1; n_q = 5'd8; vn_mode = 1'b0; in_valid = 1'b1;
        tick();
        start = 1'b0; n_q = 5'd0; vn_mode = 1'b1;   // latched values must hold
        chk("qk_busy", 20'(busy), 20'd1);
        chk("qk_in_ready", 20'(in_ready), 20'd1);
        chk("qk_state", 20'(state_dbg), S_WR_Q);
        chk("qk_first_inst", inst, 20'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("qk_wr_q", inst, QWR | adr(i));
        end
        chk("qk_wr_k_state", 20'(state_dbg), S_WR_K);
        phase_k(20'd0);
        phase_ldk(20'd0);
        phase_gap(20'd0);
        phase_exec(20'd0, 8, 9);
        chk("qk_drain_state", 20'(state_dbg), S_DRAIN);
        fifo_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("qk_drain_idle_inst", inst, 20'd0);
            chk("qk_drain_busy", 20'(busy), 20'd1);
        end
        for (int i = 0; i < 8; i++) begin
            fifo_valid = 1'b1;
            tick();
            chk("qk_drain_inst", inst, 20'd0);
            chk("qk_drain_done", 20'(done), 20'd0);
        end
        fifo_valid = 1'b0;
        chk("qk_sfp_state", 20'(state_dbg), S_SFP);
        for (int s = 0; s < 8; s++) begin
            tick();
            chk("qk_sfp_inst", inst, SFP);
            chk("qk_sfp_done", 20'(done), 20'(s == 7));
        end
        chk("qk_fin_state", 20'(state_dbg), S_FIN);
        chk("qk_fin_busy", 20'(busy), 20'd1);
        tick();
        chk("qk_end_inst", inst, 20'd0);
        chk("qk_end_busy", 20'(busy), 20'd0);
        chk("qk_end_done", 20'(done), 20'd0);
        chk("qk_end_state", 20'(state_dbg), S_IDLE);

        // ------- WR_Q backpressure n_q=4, ignored start in WR_K, reset in EXEC -------
        vn_mode = 1'b0;
        start = 1'b1; n_q = 5'd4; in_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("bp_in_ready", 20'(in_ready), 20'd1);
        a = 0;
        for (int j = 0; j < 7; j++) begin
            in_valid = pat[j][0];
            tick();
            if (pat[j] != 0) begin
                chk("bp_qwr", inst, QWR | adr(a));
                a++;
            end else begin
                chk("bp_gap", inst, 20'd0);
            end
        end
        chk("bp_wr_k_state", 20'(state_dbg), S_WR_K);
        in_valid = 1'b0;
        start = 1'b1; n_q = 5'd3; vn_mode = 1'b1;
        tick();
        start = 1'b0; vn_mode = 1'b0;
        chk("busy_start_state", 20'(state_dbg), S_WR_K);
        chk("busy_start_inst", inst, 20'd0);
        chk("busy_start_in_ready", 20'(in_ready), 20'd1);
        in_valid = 1'b1;
        phase_k(20'd0);
        phase_ldk(20'd0);
        phase_gap(20'd0);
        phase_exec(20'd0, 4, 4);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_inst", inst, 20'd0);
        chk("async_rst_busy", 20'(busy), 20'd0);
        chk("async_rst_in_ready", 20'(in_ready), 20'd0);
        chk("async_rst_done", 20'(done), 20'd0);
        chk("async_rst_state", 20'(state_dbg), S_IDLE);
        #1;
        reset = 1'b0;
        tick();
        chk("post_rst_state", 20'(state_dbg), S_IDLE);

        // ---------------- VN pass, n_q=16 ----------------
        start = 1'b1; n_q = 5'd16; vn_mode = 1'b1; in_valid = 1'b1;
        tick();
        start = 1'b0; vn_mode = 1'b0;
        chk("vn_first_inst", inst, VN);
        chk("vn_busy", 20'(busy), 20'd1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("vn_wr_q", inst, VN | QWR | adr(i));
        end
        phase_k(VN);
        phase_ldk(VN);
        phase_gap(VN);
        phase_exec(VN, 16, 17);
        chk("vn_drain_state", 20'(state_dbg), S_DRAIN);
        for (int i = 0; i < 16; i++) begin
            fifo_valid = 1'b1;
            tick();
            chk("vn_drain_inst", inst, VN);
            chk("vn_done", 20'(done), 20'(i == 15));
            fifo_valid = 1'b0;
            if ((i % 5) == 2) begin
                tick();
                chk("vn_drain_stall_done", 20'(done), 20'd0);
                chk("vn_drain_stall_state", 20'(state_dbg), S_DRAIN);
            end
        end
        chk("vn_fin_state", 20'(state_dbg), S_FIN);
        tick();
        chk("vn_end_inst", inst, 20'd0);
        chk("vn_end_busy", 20'(busy), 20'd0);
        chk("vn_end_done", 20'(done), 20'd0);
        chk("vn_end_state", 20'(state_dbg), S_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
